// File: rtl/k2_program_loader.sv
// Host-side loader for the K2 instruction memory: accepts a framed program over a valid/ready
// byte stream, writes it into imem and releases the core only after a checksum-verified load.
module k2_program_loader #(
    parameter int          WIDTH  = 8,
    parameter int          DEPTH  = 16,
    parameter int          ADDR_W = 4,
    parameter logic [3:0]  SYNC   = 4'hA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WIDTH-1:0]  imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0]  csum_q, csum_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [WIDTH-1:0]  imem_wdata_q, imem_wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;
    logic              accept;

    // in_ready is decoded from state alone so a byte offered on the same cycle as start is never taken.
    assign busy      = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign in_ready  = busy;
    assign accept    = in_valid && in_ready;

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;

    always_comb begin
        // NOTE: every _d signal gets its hold value first so no path through the case infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        csum_d       = csum_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_reset_d  = cpu_reset_q;
        load_done_d  = load_done_q;
        load_err_d   = load_err_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d     = S_HDR;
                    cpu_reset_d = 1'b1;
                    load_done_d = 1'b0;
                    load_err_d  = 1'b0;
                    csum_d      = '0;
                    idx_d       = '0;
                end
            end
            S_HDR: begin
                if (accept) begin
                    if (in_data[WIDTH-1 -: 4] == SYNC) begin
                        state_d = S_DATA;
                        cnt_d   = in_data[ADDR_W-1:0];
                        csum_d  = in_data;
                    end else begin
                        state_d    = S_ERR;
                        load_err_d = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = idx_q;
                    imem_wdata_d = in_data;
                    csum_d       = csum_q ^ in_data;
                    // Saturate rather than wrap; the header count already bounds the frame length.
                    idx_d        = (idx_q == LAST_ADDR) ? idx_q : idx_q + ADDR_W'(1);
                    if (idx_q == cnt_q) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d     = S_DONE;
                        cpu_reset_d = 1'b0;
                        load_done_d = 1'b1;
                    end else begin
                        state_d    = S_ERR;
                        load_err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            csum_q       <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            csum_q       <= csum_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
        end
    end

endmodule
